// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: turns mm/wm strobes into a held req/ack memory transaction; ports: mm/wm/flush/addr/wdata from pipeline, mem_* to data memory, rdata/rvalid/stall/err back to pipeline
module mem_access_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mm,
  input  logic              wm,
  input  logic              flush,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              stall,
  output logic              err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic start, last;
  // cnt holds the number of ACCESS cycles already completed, so the TIMEOUT-th cycle sees TIMEOUT-1
  always_comb begin
    start = state == IDLE && (mm | wm) && !flush;
    last  = state == ACCESS && (mem_ack || cnt == CW'(TIMEOUT - 1));
    stall = start || state == ACCESS;
    next  = start ? ACCESS : last ? DONE : state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      err       <= 1'b0;
    end else begin
      state   <= next;
      mem_req <= next == ACCESS;
      rvalid  <= last && !mem_we;
      if (start) begin
        mem_addr  <= addr;
        mem_wdata <= wdata;
        mem_we    <= wm;
        cnt       <= '0;
      end
      if (state == ACCESS) cnt <= cnt + 1'b1;
      if (last && !mem_we) rdata <= mem_ack ? mem_rdata : '0;
      if (last && !mem_ack) err <= 1'b1;
    end
  end
endmodule
